// File: rtl/mips_cpu_pkg.sv
// Shared types and constants for the MIPS CPU front end.
package mips_cpu_pkg;

  typedef enum logic [2:0] {
    IDLE,
    REQ,
    RESP,
    HOLD,
    HALT
  } ifetch_state_t;

  localparam logic [31:0] HALT_ADDR_DEFAULT = 32'h0000_0000;

endpackage

// File: rtl/mips_cpu_byteswap.sv
// Combinational 32-bit byte reversal (lane b takes source byte 3-b).
module mips_cpu_byteswap (
  input  logic [31:0] data_i,
  output logic [31:0] data_o
);

  for (genvar b = 0; b < 4; b++) begin : g_byte
    assign data_o[8*b +: 8] = data_i[8*(3-b) +: 8];
  end

endmodule

// File: rtl/mips_cpu_ifetch.sv
// Instruction fetch unit: PC handshake in, Avalon-MM read, held instruction out.
// Optional MIPS_CPU_IFETCH_BYTESWAP_EN byte-reverses fetched words.
module mips_cpu_ifetch
  import mips_cpu_pkg::*;
#(
  parameter logic [31:0] HALT_ADDR = HALT_ADDR_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] pc_in,
  input  logic        pc_valid,
  output logic        pc_ready,
  input  logic        flush,
  output logic [31:0] imem_address,
  output logic        imem_read,
  input  logic        imem_waitrequest,
  input  logic [31:0] imem_readdata,
  input  logic        imem_readdatavalid,
  output logic [31:0] instr_out,
  output logic [31:0] instr_pc,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic        halted,
  output logic        fault
);

  ifetch_state_t state_q;
  logic [31:0]   addr_q, instr_q, ipc_q, rdata_fmt;
  logic          read_q, valid_q, halted_q, fault_q, drop_q;

`ifdef MIPS_CPU_IFETCH_BYTESWAP_EN
  mips_cpu_byteswap u_bswap (.data_i(imem_readdata), .data_o(rdata_fmt));
`else
  assign rdata_fmt = imem_readdata;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      addr_q   <= '0;
      read_q   <= 1'b0;
      instr_q  <= '0;
      ipc_q    <= '0;
      valid_q  <= 1'b0;
      halted_q <= 1'b0;
      fault_q  <= 1'b0;
      drop_q   <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: if (pc_valid && !flush) begin
          if (pc_in == HALT_ADDR) begin
            state_q  <= HALT;
            halted_q <= 1'b1;
          end else if (pc_in[1:0] != 2'b00) begin
            state_q  <= HALT;
            halted_q <= 1'b1;
            fault_q  <= 1'b1;
          end else begin
            state_q <= REQ;
            addr_q  <= pc_in;
            ipc_q   <= pc_in;
            read_q  <= 1'b1;
          end
        end
        // A flushed read still completes on the bus; its data is discarded later.
        REQ: begin
          if (flush) drop_q <= 1'b1;
          if (!imem_waitrequest) begin
            read_q  <= 1'b0;
            state_q <= RESP;
          end
        end
        RESP: begin
          if (imem_readdatavalid) begin
            if (drop_q || flush) begin
              drop_q  <= 1'b0;
              state_q <= IDLE;
            end else begin
              instr_q <= rdata_fmt;
              valid_q <= 1'b1;
              state_q <= HOLD;
            end
          end else if (flush) begin
            drop_q <= 1'b1;
          end
        end
        HOLD: if (flush || instr_ready) begin
          valid_q <= 1'b0;
          state_q <= IDLE;
        end
        HALT: ;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign pc_ready     = (state_q == IDLE) && !flush;
  assign imem_address = addr_q;
  assign imem_read    = read_q;
  assign instr_out    = instr_q;
  assign instr_pc     = ipc_q;
  assign instr_valid  = valid_q;
  assign halted       = halted_q;
  assign fault        = fault_q;

endmodule

// File: tb/tb_mips_cpu_ifetch.sv
// Randomized fetch bench: bench plays PC unit, Avalon slave and decoder,
// and predicts each transaction's timeline from the handshake rules.
module tb_mips_cpu_ifetch;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] pc_in;
  logic        pc_valid, pc_ready, flush;
  logic [31:0] imem_address, imem_readdata;
  logic        imem_read, imem_waitrequest, imem_readdatavalid;
  logic [31:0] instr_out, instr_pc;
  logic        instr_valid, instr_ready, halted, fault;

  int total = 0;
  int bad   = 0;

  mips_cpu_ifetch dut (
    .clk(clk), .rst(rst), .pc_in(pc_in), .pc_valid(pc_valid), .pc_ready(pc_ready),
    .flush(flush), .imem_address(imem_address), .imem_read(imem_read),
    .imem_waitrequest(imem_waitrequest), .imem_readdata(imem_readdata),
    .imem_readdatavalid(imem_readdatavalid), .instr_out(instr_out), .instr_pc(instr_pc),
    .instr_valid(instr_valid), .instr_ready(instr_ready), .halted(halted), .fault(fault)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] exp_word(input logic [31:0] w);
`ifdef MIPS_CPU_IFETCH_BYTESWAP_EN
    logic [31:0] r = '0;
    for (int i = 0; i < 4; i++) r = (r << 8) | ((w >> (8 * i)) & 32'hFF);
    return r;
`else
    return w;
`endif
  endfunction

  task automatic idle_inputs();
    pc_valid = 1'b0; pc_in = $urandom; flush = 1'b0;
    imem_waitrequest = 1'b0; imem_readdatavalid = 1'b0; imem_readdata = $urandom;
    instr_ready = 1'b0;
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, ".read"}, 32'(imem_read), 32'd0);
    chk({tag, ".addr"}, imem_address, 32'd0);
    chk({tag, ".iout"}, instr_out, 32'd0);
    chk({tag, ".ipc"}, instr_pc, 32'd0);
    chk({tag, ".ivld"}, 32'(instr_valid), 32'd0);
    chk({tag, ".halt"}, 32'(halted), 32'd0);
    chk({tag, ".fault"}, 32'(fault), 32'd0);
    chk({tag, ".pcrdy"}, 32'(pc_ready), 32'd1);
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1'b1;
    tick(); tick();
    rst = 1'b0;
    #1;
    check_reset_vals("reset");
  endtask

  // One fetch. Cycle 0 = accept; bus read held through waits; data returns at
  // r_cyc; flush_at<0 means no flush; junk adds stray readdatavalid pulses.
  task automatic fetch(input logic [31:0] pc, input logic [31:0] data, input int waits,
                       input int rdv_dly, input int rdy_dly, input int flush_at, input bit junk);
    int  r_cyc, end_cyc, nreads;
    bit  dropped, exp_rd, exp_v;
    r_cyc   = waits + 2 + rdv_dly;
    dropped = (flush_at >= 1) && (flush_at < r_cyc);
    if (dropped) end_cyc = r_cyc + 1;
    else if (flush_at > r_cyc && flush_at <= r_cyc + 1 + rdy_dly) end_cyc = flush_at + 1;
    else end_cyc = r_cyc + 2 + rdy_dly;
    nreads = 0;
    for (int c = 0; c <= end_cyc; c++) begin
      pc_valid           = (c == 0);
      pc_in              = (c == 0) ? pc : $urandom;
      imem_waitrequest   = (c >= 1) && (c <= waits);
      imem_readdatavalid = (c == r_cyc) ||
                           (junk && c >= 1 && c <= waits + 1) ||
                           (junk && c > r_cyc && c < end_cyc);
      imem_readdata      = (c == r_cyc) ? data : $urandom;
      flush              = (c == flush_at);
      instr_ready        = (c >= r_cyc + 1 + rdy_dly);
      #1;
      exp_rd = (c >= 1) && (c <= waits + 1);
      exp_v  = !dropped && (c > r_cyc) && (c < end_cyc);
      if (c == 0) chk("accept.pcrdy", 32'(pc_ready), 32'd1);
      chk("bus.read", 32'(imem_read), 32'(exp_rd));
      if (exp_rd) chk("bus.addr", imem_address, pc);
      chk("dec.valid", 32'(instr_valid), 32'(exp_v));
      if (exp_v) begin
        chk("dec.instr", instr_out, exp_word(data));
        chk("dec.pc", instr_pc, pc);
      end
      if (c == end_cyc) begin
        chk("done.pcrdy", 32'(pc_ready), 32'd1);
        chk("done.halt", 32'(halted), 32'd0);
      end
      if (imem_read && !imem_waitrequest) nreads++;
      tick();
    end
    chk("bus.nreads", 32'(nreads), 32'd1);
    idle_inputs();
  endtask

  task automatic halt_case(input logic [31:0] pc, input bit exp_fault);
    do_reset();
    pc_valid = 1'b1; pc_in = pc;
    #1;
    chk("halt.accept", 32'(pc_ready), 32'd1);
    tick();
    idle_inputs();
    #1;
    chk("halt.halted", 32'(halted), 32'd1);
    chk("halt.fault", 32'(fault), 32'(exp_fault));
    for (int i = 0; i < 4; i++) begin
      pc_valid = 1'b1; pc_in = 32'h0000_1000; flush = $urandom_range(0, 1);
      #1;
      chk("halt.pcrdy", 32'(pc_ready), 32'd0);
      chk("halt.read", 32'(imem_read), 32'd0);
      tick();
      chk("halt.sticky", 32'(halted), 32'd1);
      chk("halt.fsticky", 32'(fault), 32'(exp_fault));
    end
    idle_inputs();
  endtask

  initial begin
    idle_inputs();
    rst = 1'b1;
    do_reset();

    // zero-wait fetch: valid at cycle 3
    fetch(32'hBFC0_0000, 32'h2408_0005, 0, 0, 0, -1, 1'b0);
    // three wait states
    fetch(32'h0040_0010, $urandom, 3, 0, 0, -1, 1'b0);
    // flush while the read is outstanding
    fetch(32'h0040_0020, $urandom, 0, 0, 0, 1, 1'b0);
    // decode backpressure for 5 cycles, stray readdatavalid ignored
    fetch(32'h0040_0030, $urandom, 1, 1, 5, -1, 1'b1);
    // flush together with instr_ready in HOLD
    fetch(32'h0040_0040, $urandom, 0, 0, 2, 5, 1'b0);
    // byte order of the delivered word
    fetch(32'h0040_0050, 32'h1234_5678, 0, 0, 0, -1, 1'b0);

    for (int n = 0; n < 60; n++) begin
      int w, d, r, f, rc, sel;
      logic [31:0] pc;
      w  = $urandom_range(0, 4);
      d  = $urandom_range(0, 3);
      r  = $urandom_range(0, 4);
      rc = w + 2 + d;
      sel = $urandom_range(0, 3);
      if (sel == 0) f = $urandom_range(1, rc - 1);
      else if (sel == 1) f = $urandom_range(rc + 1, rc + 1 + r);
      else f = -1;
      pc = $urandom & 32'hFFFF_FFFC;
      if (pc == 32'h0) pc = 32'h4;
      fetch(pc, $urandom, w, d, r, f, 1'($urandom_range(0, 1)));
    end

    // reset in the middle of a stalled read
    do_reset();
    pc_valid = 1'b1; pc_in = 32'h0000_0100; imem_waitrequest = 1'b1;
    tick();
    pc_valid = 1'b0;
    chk("rstmid.read", 32'(imem_read), 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0; imem_waitrequest = 1'b0;
    imem_readdatavalid = 1'b1; imem_readdata = 32'hDEAD_BEEF;
    #1;
    check_reset_vals("rstmid");
    tick();
    idle_inputs();
    #1;
    chk("rstmid.late", 32'(instr_valid), 32'd0);
    chk("rstmid.pcrdy", 32'(pc_ready), 32'd1);
    chk("rstmid.read2", 32'(imem_read), 32'd0);

    halt_case(32'h0000_0000, 1'b0);
    halt_case(32'h0000_0102, 1'b1);
    halt_case(($urandom & 32'hFFFF_FFFC) | 32'h0000_1001, 1'b1);

    do_reset();
    fetch(32'h0000_0200, $urandom, 0, 0, 0, -1, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mips_cpu_ifetch.md
MIPS_CPU_IFETCH -- requirements
Module: mips_cpu_ifetch

Interface
REQ-001 Parameter HALT_ADDR SHALL be: HALT_ADDR, 32'h0000_0000, fetch address that halts the CPU instead of issuing a bus read.
REQ-002 clk  in  1  sole clock; all state updates on rising edge.
REQ-003 rst  in  1  synchronous, active-high reset.
REQ-004 pc_in  in  32  fetch address from the PC unit.
REQ-005 pc_valid  in  1  pc_in is valid this cycle.
REQ-006 pc_ready  out  1  block accepts pc_in; a transfer occurs when pc_valid && pc_ready.
REQ-007 flush  in  1  discard any in-flight or held instruction (taken branch/jump).
REQ-008 imem_address  out  32  instruction bus address, registered.
REQ-009 imem_read  out  1  instruction bus read strobe, registered.
REQ-010 imem_waitrequest  in  1  bus stall; read and address held while high.
REQ-011 imem_readdata  in  32  bus read data.
REQ-012 imem_readdatavalid  in  1  imem_readdata valid this cycle.
REQ-013 instr_out  out  32  fetched instruction word.
REQ-014 instr_pc  out  32  address instr_out was fetched from.
REQ-015 instr_valid  out  1  instr_out/instr_pc valid for decode.
REQ-016 instr_ready  in  1  decode consumes the instruction when instr_valid && instr_ready.
REQ-017 halted  out  1  sticky; CPU stopped (halt address or fault).
REQ-018 fault  out  1  sticky; misaligned fetch address accepted.

Function
REQ-019 States SHALL be IDLE, REQ, RESP, HOLD, HALT; pc_ready SHALL be 1 only in IDLE with flush low.
REQ-020 IDLE, accepted pc_in == HALT_ADDR -> HALT, halted=1 next cycle, no bus read.
REQ-021 IDLE, accepted pc_in[1:0] != 0 -> HALT, halted=1 and fault=1 next cycle, no bus read; the halt check takes priority.
REQ-022 IDLE, other accepted pc_in -> REQ; imem_address=instr_pc=pc_in and imem_read=1 from the next cycle.
REQ-023 REQ: imem_read and imem_address SHALL stay stable while imem_waitrequest=1; when imem_waitrequest=0, imem_read drops next cycle -> RESP.
REQ-024 RESP: on imem_readdatavalid, capture data into instr_out -> HOLD (instr_valid=1 next cycle); if the drop flag is set, do not capture -> IDLE, clear drop.
REQ-025 HOLD: instr_out/instr_pc/instr_valid stable until instr_ready=1 -> IDLE, instr_valid=0 next cycle.
REQ-026 Minimum latency: accept at cycle N, imem_read at N+1, zero-wait bus and readdatavalid at N+2 -> instr_valid at N+3.
REQ-027 flush in REQ or RESP SHALL set the drop flag without abandoning the bus read (Avalon rule); flush in HOLD -> IDLE with instr_valid=0 next cycle; flush in IDLE blocks acceptance.
REQ-028 flush and instr_ready together in HOLD SHALL behave as flush.
REQ-029 imem_readdatavalid outside RESP SHALL be ignored.
REQ-030 HALT SHALL be absorbing until rst: no bus activity, pc_ready=0, flush ignored.

Reset
REQ-031 On rst: state=IDLE, imem_read=0, imem_address=0, instr_out=0, instr_pc=0, instr_valid=0, halted=0, fault=0, drop=0.
REQ-032 rst SHALL override every input, including mid-transaction; imem_read=0 in the following cycle and any later readdatavalid is ignored.

Configuration
REQ-033 Macro MIPS_CPU_IFETCH_BYTESWAP_EN defined: instr_out SHALL be imem_readdata byte-reversed ({[7:0],[15:8],[23:16],[31:24]}); undefined: instr_out = imem_readdata unchanged.

Structure
REQ-034 Package mips_cpu_pkg SHALL hold ifetch_state_t enum and the default halt-address constant.
REQ-035 Byte reversal SHALL be a sub-module mips_cpu_byteswap (combinational, 32-bit), instantiated only under the macro.

Verification
REQ-036 Zero-wait fetch: pc_in=32'hBFC0_0000 accepted at cycle 0, readdata=32'h2408_0005 at cycle 2 -> instr_valid=1 at cycle 3, instr_pc=32'hBFC0_0000.
REQ-037 Wait states: imem_waitrequest high 3 cycles -> imem_read/imem_address stable all 4 cycles, single read issued.
REQ-038 Flush in REQ: flush at cycle 1 -> read completes, instr_valid never rises, pc_ready=1 after readdatavalid.
REQ-039 Halt/fault: pc_in=32'h0 -> halted=1, fault=0, imem_read stays 0; pc_in=32'h0000_0102 -> halted=1, fault=1.
REQ-040 Backpressure and reset: instr_ready low 5 cycles holds instr_out stable; rst in REQ -> imem_read=0 next cycle, all outputs at reset values; with macro defined, readdata 32'h1234_5678 -> instr_out 32'h7856_3412.
